// File: rtl/plugboard_pairs_pkg.sv
// Shared definitions for the Enigma plugboard:
// letter width and configuration FSM states.
package plugboard_pairs_pkg;

    localparam int LETTER_W = 26;

    typedef enum logic {
        PB_IDLE       = 1'b0,
        PB_HAVE_FIRST = 1'b1
    } pb_state_e;

endpackage

// File: rtl/plugboard_lookup.sv
// Combinational swap of one letter against the
// committed pair table; non-matching letters pass.
module plugboard_lookup
    import plugboard_pairs_pkg::*;
#(
    parameter int W = LETTER_W,
    parameter int N = 10
) (
    input  logic [W-1:0]   letter_in,
    input  logic [N*W-1:0] pair_a,
    input  logic [N*W-1:0] pair_b,
    output logic [W-1:0]   letter_out
);

    // empty entries are zero and never match a one-hot letter
    always_comb begin
        letter_out = letter_in;
        if ($onehot(letter_in)) begin
            for (int i = 0; i < N; i++) begin
                if (pair_a[i*W +: W] == letter_in) begin
                    letter_out = pair_b[i*W +: W];
                end else if (pair_b[i*W +: W] == letter_in) begin
                    letter_out = pair_a[i*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/plugboard_pairs.sv
// Run-time programmable plugboard: pair entry FSM,
// pair table and N_CH registered lookup channels.
module plugboard_pairs
    import plugboard_pairs_pkg::*;
#(
    parameter int W         = LETTER_W,
    parameter int MAX_PAIRS = 10,
    parameter int N_CH      = 2,
    localparam int CW       = $clog2(MAX_PAIRS + 1)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cfg_mode,
    input  logic              clear,
    input  logic [W-1:0]      key_in,
    input  logic              key_valid,
    input  logic [N_CH*W-1:0] ch_in,
    input  logic [N_CH-1:0]   ch_valid,
    output logic [N_CH*W-1:0] ch_out,
    output logic [N_CH-1:0]   ch_out_valid,
    output logic [CW-1:0]     pair_count,
    output logic              cfg_busy,
    output logic              cfg_error,
    output logic              table_full
);

    pb_state_e state_q, state_d;
    logic [W-1:0] first_q, first_d;
    logic [W-1:0] used_q, used_d;
    logic [CW-1:0] count_q, count_d;
    logic [MAX_PAIRS-1:0][W-1:0] tab_a_q, tab_a_d;
    logic [MAX_PAIRS-1:0][W-1:0] tab_b_q, tab_b_d;
    logic err_q, err_d;
    logic [N_CH*W-1:0] out_q, out_d;
    logic [N_CH-1:0] out_valid_q;
    logic [N_CH-1:0][W-1:0] lk_out;
    logic full;
    logic key_free;

    assign full = (count_q == CW'(MAX_PAIRS));
    assign key_free = $onehot(key_in) && ((key_in & used_q) == '0);

    // pair entry FSM, table write and clear
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        used_d  = used_q;
        count_d = count_q;
        tab_a_d = tab_a_q;
        tab_b_d = tab_b_q;
        err_d   = 1'b0;
        if (clear) begin
            state_d = PB_IDLE;
            first_d = '0;
            used_d  = '0;
            count_d = '0;
            tab_a_d = '0;
            tab_b_d = '0;
        end else begin
            unique case (state_q)
                PB_IDLE: begin
                    if (cfg_mode && key_valid) begin
                        if (key_free && !full) begin
                            first_d = key_in;
                            state_d = PB_HAVE_FIRST;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                PB_HAVE_FIRST: begin
                    state_d = PB_IDLE;
                    if (!cfg_mode) begin
                        first_d = '0;
                    end else if (!key_valid) begin
                        state_d = PB_HAVE_FIRST;
                    end else if (key_free && key_in != first_q) begin
                        for (int i = 0; i < MAX_PAIRS; i++) begin
                            if (CW'(i) == count_q) begin
                                tab_a_d[i] = first_q;
                                tab_b_d[i] = key_in;
                            end
                        end
                        used_d  = used_q | first_q | key_in;
                        count_d = count_q + 1'b1;
                        first_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        first_d = '0;
                    end
                end
                default: state_d = PB_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        plugboard_lookup #(
            .W (W),
            .N (MAX_PAIRS)
        ) u_lookup (
            .letter_in  (ch_in[c*W +: W]),
            .pair_a     (tab_a_q),
            .pair_b     (tab_b_q),
            .letter_out (lk_out[c])
        );
    end

    // capture swapped letters only on a valid strobe
    always_comb begin
        out_d = out_q;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_valid[c]) begin
                out_d[c*W +: W] = lk_out[c];
            end
        end
    end

    // state and output registers
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= PB_IDLE;
            first_q     <= '0;
            used_q      <= '0;
            count_q     <= '0;
            tab_a_q     <= '0;
            tab_b_q     <= '0;
            err_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            used_q      <= used_d;
            count_q     <= count_d;
            tab_a_q     <= tab_a_d;
            tab_b_q     <= tab_b_d;
            err_q       <= err_d;
            out_q       <= out_d;
            out_valid_q <= ch_valid;
        end
    end

    assign ch_out       = out_q;
    assign ch_out_valid = out_valid_q;
    assign pair_count   = count_q;
    assign cfg_busy     = (state_q == PB_HAVE_FIRST);
    assign cfg_error    = err_q;
    assign table_full   = full;

endmodule

// File: tb/tb_plugboard_pairs.sv
// Directed bench for plugboard_pairs with
// hand-computed expected letters and counts.
module tb_plugboard_pairs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_mode = 1'b0;
    logic        clear = 1'b0;
    logic [25:0] key_in = '0;
    logic        key_valid = 1'b0;
    logic [51:0] ch_in = '0;
    logic [1:0]  ch_valid = '0;
    logic [51:0] ch_out;
    logic [1:0]  ch_out_valid;
    logic [3:0]  pair_count;
    logic        cfg_busy;
    logic        cfg_error;
    logic        table_full;

    int n_checks = 0;
    int n_fail = 0;

    plugboard_pairs dut (
        .CLOCK_50     (clk),
        .reset        (rst_n),
        .cfg_mode     (cfg_mode),
        .clear        (clear),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .ch_in        (ch_in),
        .ch_valid     (ch_valid),
        .ch_out       (ch_out),
        .ch_out_valid (ch_out_valid),
        .pair_count   (pair_count),
        .cfg_busy     (cfg_busy),
        .cfg_error    (cfg_error),
        .table_full   (table_full)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] L(input int n);
        return 26'(1) << n;
    endfunction

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [25:0] k);
        key_in = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in = '0;
    endtask

    task automatic lk(input logic [1:0] v,
                      input logic [25:0] l0,
                      input logic [25:0] l1);
        ch_in = {l1, l0};
        ch_valid = v;
        tick();
        ch_valid = '0;
        ch_in = '0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_out", ch_out, 0);
        check("rst_ov", ch_out_valid, 0);
        check("rst_cnt", pair_count, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_err", cfg_error, 0);
        check("rst_full", table_full, 0);
        rst_n = 1'b1;
        tick();

        // pass-through on empty table
        lk(2'b01, L(0), '0);
        check("pt_a", ch_out[25:0], L(0));
        check("pt_v", ch_out_valid, 2'b01);
        tick();
        check("pt_v_drop", ch_out_valid, 0);
        check("pt_hold", ch_out[25:0], L(0));

        // program A-Q
        cfg_mode = 1'b1;
        key(L(0));
        check("aq_busy", cfg_busy, 1);
        check("aq_cnt0", pair_count, 0);
        key(L(16));
        check("aq_idle", cfg_busy, 0);
        check("aq_cnt1", pair_count, 1);
        check("aq_err", cfg_error, 0);
        lk(2'b11, L(0), L(16));
        check("aq_ch0", ch_out[25:0], L(16));
        check("aq_ch1", ch_out[51:26], L(0));
        check("aq_v", ch_out_valid, 2'b11);

        // E then used A -> error
        key(L(4));
        check("ea_busy", cfg_busy, 1);
        key(L(0));
        check("ea_err", cfg_error, 1);
        check("ea_cnt", pair_count, 1);
        check("ea_busy0", cfg_busy, 0);
        tick();
        check("ea_err1c", cfg_error, 0);
        lk(2'b01, L(4), '0);
        check("ea_e_pt", ch_out[25:0], L(4));

        // multi-hot first key -> error
        key(L(5) | L(6));
        check("mh_err", cfg_error, 1);
        check("mh_busy", cfg_busy, 0);
        // multi-hot lookup passes through
        lk(2'b10, '0, L(0) | L(16));
        check("mh_pt", ch_out[51:26], L(0) | L(16));

        // cfg_mode drop while holding first
        key(L(5));
        check("cm_busy", cfg_busy, 1);
        cfg_mode = 1'b0;
        tick();
        check("cm_idle", cfg_busy, 0);
        check("cm_err", cfg_error, 0);
        key(L(6));
        check("cm_ign", cfg_busy, 0);
        check("cm_cnt", pair_count, 1);
        cfg_mode = 1'b1;

        // fill remaining nine pairs
        key(L(1)); key(L(2));
        key(L(3)); key(L(4));
        key(L(5)); key(L(6));
        key(L(7)); key(L(8));
        key(L(9)); key(L(10));
        key(L(11)); key(L(12));
        key(L(13)); key(L(14));
        key(L(15)); key(L(17));
        key(L(18)); key(L(19));
        check("fl_cnt", pair_count, 10);
        check("fl_full", table_full, 1);
        lk(2'b11, L(17), L(19));
        check("fl_ch0", ch_out[25:0], L(15));
        check("fl_ch1", ch_out[51:26], L(18));
        key(L(20));
        check("fl_err", cfg_error, 1);
        check("fl_busy", cfg_busy, 0);

        // clear wins over same-cycle key
        clear = 1'b1;
        key(L(21));
        clear = 1'b0;
        check("cl_cnt", pair_count, 0);
        check("cl_full", table_full, 0);
        check("cl_busy", cfg_busy, 0);
        check("cl_err", cfg_error, 0);
        lk(2'b01, L(0), '0);
        check("cl_a_pt", ch_out[25:0], L(0));

        // commit and lookup on the same edge
        key(L(1));
        key_in = L(2);
        key_valid = 1'b1;
        ch_in = {26'(0), L(2)};
        ch_valid = 2'b01;
        tick();
        key_valid = 1'b0;
        ch_valid = '0;
        check("se_old", ch_out[25:0], L(2));
        check("se_cnt", pair_count, 1);
        lk(2'b01, L(2), '0);
        check("se_new", ch_out[25:0], L(1));

        // async reset while holding first
        key(L(3));
        check("ar_busy", cfg_busy, 1);
        rst_n = 1'b0;
        #1;
        check("ar_out", ch_out, 0);
        check("ar_cnt", pair_count, 0);
        check("ar_busy0", cfg_busy, 0);
        check("ar_ov", ch_out_valid, 0);
        #2;
        rst_n = 1'b1;
        tick();
        lk(2'b01, L(3), '0);
        check("ar_d_pt", ch_out[25:0], L(3));
        lk(2'b10, '0, L(1));
        check("ar_b_pt", ch_out[51:26], L(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
